imm_pack_unit: RTL
==================

IMM_PACK_UNIT -- requirements
Module: imm_pack_unit

Interface
REQ-001 SHALL expose clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL expose rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL expose in_valid  input  1  request present.
REQ-004 SHALL expose in_ready  output  1  unit accepts request this cycle.
REQ-005 SHALL expose imm  input  32  immediate value to encode.
REQ-006 SHALL expose imm_type  input  3  000 I, 001 S, 010 B, 011 J, 100 U, 101-111 illegal.
REQ-007 SHALL expose out_valid  output  1  result present.
REQ-008 SHALL expose out_ready  input  1  consumer accepts result this cycle.
REQ-009 SHALL expose packed_field  output  25  instruction bits [31:7] carrying the immediate; non-immediate positions 0.
REQ-010 SHALL expose imm_fit  output  1  immediate exactly representable in the chosen format.
REQ-011 SHALL expose miss_count  output  8  saturating count of delivered results with imm_fit=0.

Function
REQ-012 SHALL pack I: field[24:13]=imm[11:0].
REQ-013 SHALL pack S: field[24:18]=imm[11:5], field[4:0]=imm[4:0].
REQ-014 SHALL pack B: field[24]=imm[12], field[23:18]=imm[10:5], field[4:1]=imm[4:1], field[0]=imm[11].
REQ-015 SHALL pack J: field[24]=imm[20], field[23:14]=imm[10:1], field[13]=imm[11], field[12:5]=imm[19:12].
REQ-016 SHALL pack U: field[24:5]=imm[31:12].
REQ-017 SHALL, for illegal imm_type, output packed_field=0 and imm_fit=0.
REQ-018 SHALL compute fit: I/S imm[31:11] all equal; B imm[31:12] all equal and imm[0]=0; J imm[31:20] all equal and imm[0]=0; U imm[11:0]=0.
REQ-019 SHALL be a two-stage pipeline: stage 1 registers imm/imm_type, stage 2 registers packed_field/imm_fit/out_valid.
REQ-020 SHALL deliver a result exactly 2 cycles after acceptance when out_ready stays high.
REQ-021 SHALL advance stage 2 when !out_valid or out_ready; stage 1 when stage 1 empty or stage 2 advances.
REQ-022 SHALL drive in_ready = !s1_valid or stage-2-advance (combinational, no bubble at full throughput).
REQ-023 SHALL hold packed_field, imm_fit and out_valid stable while out_valid=1 and out_ready=0.
REQ-024 SHALL sustain one result per cycle with in_valid and out_ready continuously high.
REQ-025 SHALL hold at most 2 requests; with both stages full and out_ready=0, in_ready=0 and no request is lost or duplicated.
REQ-026 SHALL increment miss_count on each handshake (out_valid and out_ready) with imm_fit=0, saturating at 255 (no wrap).

Reset
REQ-027 SHALL, on rst assertion, immediately clear both stage valids, out_valid=0, packed_field=0, imm_fit=0, miss_count=0.
REQ-028 SHALL discard in-flight requests on mid-operation reset; first post-reset result comes from a request accepted after rst deasserts.
REQ-029 SHALL drive in_ready=1 while both stages are empty, including during reset.

Configuration
REQ-030 SHALL support macro IMM_PACK_CHECK_EN: defined -> REQ-018 fit checking and miss_count active.
REQ-031 SHALL, without IMM_PACK_CHECK_EN, tie imm_fit=1 for legal types (0 for illegal) and hold miss_count at 0; packing and timing unchanged.

Verification
REQ-032 SHALL test I, imm=0xFFFFF800 -> packed_field=0x1000000, imm_fit=1, 2 cycles after accept.
REQ-033 SHALL test I, imm=0x00000800 -> packed_field=0x1000000, imm_fit=0, miss_count 0->1.
REQ-034 SHALL test B, imm=0x00000FFE -> packed_field=0xFC001F, imm_fit=1; U, imm=0x12345000 -> 0x2468A0, imm_fit=1.
REQ-035 SHALL test 5 back-to-back requests, out_ready low for 3 cycles mid-stream -> in_ready drops when both stages full; all 5 delivered in order, none lost.
REQ-036 SHALL test 300 non-fitting results -> miss_count saturates at 255.
REQ-037 SHALL test rst pulse with 2 requests in flight -> out_valid=0 immediately, miss_count=0, nothing delivered until a new request.

Source files
------------

// File: rtl/imm_pack_unit.sv
// imm_pack_unit: two-stage pipeline that scatters a 32-bit immediate into
// instruction bits [31:7] for the I/S/B/J/U formats.
// Optional feature: define IMM_PACK_CHECK_EN to enable representability
// checking (imm_fit) and the saturating miss_count. Without it, imm_fit is 1
// for every legal type and miss_count stays 0.
module imm_pack_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] imm,
    input  logic [2:0]  imm_type,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [24:0] packed_field,
    output logic        imm_fit,
    output logic [7:0]  miss_count
);

    localparam logic [2:0] TypeI = 3'd0;
    localparam logic [2:0] TypeS = 3'd1;
    localparam logic [2:0] TypeB = 3'd2;
    localparam logic [2:0] TypeJ = 3'd3;
    localparam logic [2:0] TypeU = 3'd4;

    // Stage 1: captured request
    logic        s1_valid_q;
    logic [31:0] s1_imm_q;
    logic [2:0]  s1_type_q;

    // Stage 2: encoded result
    logic        out_valid_q;
    logic [24:0] packed_q;
    logic        fit_q;

    logic        s2_adv;
    logic        s1_adv;
    logic [24:0] packed_d;
    logic        legal_d;
    logic        fit_d;

    // Handshake: stage 2 moves when empty or drained; stage 1 moves behind it
    always_comb begin
        s2_adv   = !out_valid_q || out_ready;
        s1_adv   = !s1_valid_q || s2_adv;
        in_ready = s1_adv;
    end

    // Scatter the stage-1 immediate into instruction bit positions
    always_comb begin
        packed_d = '0;
        legal_d  = 1'b1;
        case (s1_type_q)
            TypeI: packed_d[24:13] = s1_imm_q[11:0];
            TypeS: begin
                packed_d[24:18] = s1_imm_q[11:5];
                packed_d[4:0]   = s1_imm_q[4:0];
            end
            TypeB: begin
                packed_d[24]    = s1_imm_q[12];
                packed_d[23:18] = s1_imm_q[10:5];
                packed_d[4:1]   = s1_imm_q[4:1];
                packed_d[0]     = s1_imm_q[11];
            end
            TypeJ: begin
                packed_d[24]    = s1_imm_q[20];
                packed_d[23:14] = s1_imm_q[10:1];
                packed_d[13]    = s1_imm_q[11];
                packed_d[12:5]  = s1_imm_q[19:12];
            end
            TypeU:   packed_d[24:5] = s1_imm_q[31:12];
            default: legal_d = 1'b0;
        endcase
    end

`ifdef IMM_PACK_CHECK_EN
    // Fit: bits above the encodable range must be a pure sign extension
    always_comb begin
        fit_d = 1'b0;
        case (s1_type_q)
            TypeI, TypeS: fit_d = (s1_imm_q[31:11] == {21{s1_imm_q[31]}});
            TypeB: fit_d = (s1_imm_q[31:12] == {20{s1_imm_q[31]}}) && !s1_imm_q[0];
            TypeJ: fit_d = (s1_imm_q[31:20] == {12{s1_imm_q[31]}}) && !s1_imm_q[0];
            TypeU: fit_d = (s1_imm_q[11:0] == 12'h000);
            default: fit_d = 1'b0;
        endcase
    end
`else
    assign fit_d = legal_d;
`endif

    // Pipeline registers; reset discards anything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_imm_q    <= '0;
            s1_type_q   <= '0;
            out_valid_q <= 1'b0;
            packed_q    <= '0;
            fit_q       <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_imm_q  <= imm;
                    s1_type_q <= imm_type;
                end
            end
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    packed_q <= packed_d;
                    fit_q    <= fit_d;
                end
            end
        end
    end

`ifdef IMM_PACK_CHECK_EN
    logic [7:0] miss_q;

    // Count delivered non-fitting results, sticking at 255
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_q <= '0;
        end else if (out_valid_q && out_ready && !fit_q && (miss_q != 8'hFF)) begin
            miss_q <= miss_q + 8'd1;
        end
    end

    assign miss_count = miss_q;
`else
    assign miss_count = '0;
`endif

    assign out_valid    = out_valid_q;
    assign packed_field = packed_q;
    assign imm_fit      = fit_q;

endmodule
